// File: rtl/uart_wb_pkg.sv
// Shared constants for the UART Wishbone polling master.
//   REG_DATA / REG_STATUS : register offsets inside the UART controller
//   STAT_RX_READY         : STATUS bit set when a received byte is waiting
//   STAT_TX_IDLE          : STATUS bit set when the UART can take a new byte
//   state_t               : polling FSM states
package uart_wb_pkg;

  localparam logic [7:0] REG_DATA      = 8'h00;
  localparam logic [7:0] REG_STATUS    = 8'h04;
  localparam int         STAT_RX_READY = 0;
  localparam int         STAT_TX_IDLE  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STAT = 2'd1,
    TXW  = 2'd2,
    RXR  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_wb_poll_master.sv
// Wishbone classic initiator that reaches the UART controller without the CPU.
// A one-byte TX holding register and a one-byte RX holding register sit between
// a valid/ready byte stream and polled STATUS reads, DATA writes and DATA reads.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   wb_cyc_o .. wb_we_o     Wishbone initiator side (all outputs registered)
//   wb_ack_i, wb_dat_i      Wishbone slave response
//   tx_valid_i/tx_data_i    byte to send, taken when tx_ready_o is high
//   tx_ready_o              TX holding register empty
//   rx_valid_o/rx_data_o    received byte, released when rx_ready_i is high
//   err_o                   one-cycle pulse when a transaction times out
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | bus idle; counts down the poll gap, then polls if there is work
// STAT  | STATUS read in flight
// TXW   | one idle bus cycle, then DATA write of the TX byte until ack
// RXR   | one idle bus cycle, then DATA read into the RX byte until ack
module uart_wb_poll_master
  import uart_wb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] UART_BASE   = 32'h1000_0000,
  parameter int                    POLL_GAP    = 4,
  parameter int                    ACK_TIMEOUT = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  input  logic                      wb_ack_i,
  output logic [ADDR_WIDTH-1:0]     wb_adr_o,
  output logic [DATA_WIDTH-1:0]     wb_dat_o,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i,
  output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
  output logic                      wb_we_o,
  input  logic                      tx_valid_i,
  input  logic [7:0]                tx_data_i,
  output logic                      tx_ready_o,
  output logic                      rx_valid_o,
  output logic [7:0]                rx_data_o,
  input  logic                      rx_ready_i,
  output logic                      err_o
);

  localparam int GAP_W  = $clog2(POLL_GAP + 1);
  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [ADDR_WIDTH-1:0] ADR_DATA   = UART_BASE + ADDR_WIDTH'(REG_DATA);
  localparam logic [ADDR_WIDTH-1:0] ADR_STATUS = UART_BASE + ADDR_WIDTH'(REG_STATUS);

  state_t                  r_state;
  logic [GAP_W-1:0]        r_gap;
  logic [WAIT_W-1:0]       r_wait;
  logic                    r_cyc;
  logic                    r_stb;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_adr;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic                    r_err;
  logic                    r_tx_full;
  logic [7:0]              r_tx_byte;
  logic                    r_rx_full;
  logic [7:0]              r_rx_byte;

  logic [7:0]              w_status;
  logic                    w_done;
  logic                    w_unused_dat;

  assign w_status     = wb_dat_i[7:0];
  assign w_done       = r_stb && wb_ack_i;
  // only the low byte of the UART registers carries information
  assign w_unused_dat = ^wb_dat_i[DATA_WIDTH-1:8];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_gap     <= '0;
      r_wait    <= '0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_err     <= 1'b0;
      r_tx_full <= 1'b0;
      r_tx_byte <= '0;
      r_rx_full <= 1'b0;
      r_rx_byte <= '0;
    end else begin
      r_err <= 1'b0;

      if (r_rx_full && rx_ready_i) r_rx_full <= 1'b0;
      if (tx_valid_i && !r_tx_full) begin
        r_tx_full <= 1'b1;
        r_tx_byte <= tx_data_i;
      end

      // Ack watchdog; a timed-out transaction goes back to IDLE behind a gap
      // so it is retried by the next poll with the holding registers intact.
      if (r_stb) begin
        if (wb_ack_i) begin
          r_wait <= '0;
        end else if (r_wait == WAIT_W'(ACK_TIMEOUT - 1)) begin
          r_wait  <= '0;
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
          r_we    <= 1'b0;
          r_err   <= 1'b1;
          r_gap   <= GAP_W'(POLL_GAP);
          r_state <= IDLE;
        end else begin
          r_wait <= r_wait + WAIT_W'(1);
        end
      end

      case (r_state)
        IDLE: begin
          if (r_gap != '0) begin
            r_gap <= r_gap - GAP_W'(1);
          end else if (r_tx_full || !r_rx_full) begin
            r_state <= STAT;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= 1'b0;
            r_adr   <= ADR_STATUS;
            r_dat   <= '0;
          end
        end

        STAT: begin
          if (w_done) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            if (w_status[STAT_RX_READY] && !r_rx_full) begin
              r_state <= RXR;
            end else if (w_status[STAT_TX_IDLE] && r_tx_full) begin
              r_state <= TXW;
            end else begin
              r_state <= IDLE;
              r_gap   <= GAP_W'(POLL_GAP);
            end
          end
        end

        // stb low on entry is the mandatory idle bus cycle after the STATUS ack
        TXW: begin
          if (!r_stb) begin
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
            r_we  <= 1'b1;
            r_adr <= ADR_DATA;
            r_dat <= DATA_WIDTH'(r_tx_byte);
          end else if (wb_ack_i) begin
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_tx_full <= 1'b0;
            r_state   <= IDLE;
          end
        end

        RXR: begin
          if (!r_stb) begin
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
            r_we  <= 1'b0;
            r_adr <= ADR_DATA;
            r_dat <= '0;
          end else if (wb_ack_i) begin
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_rx_byte <= w_status;
            r_rx_full <= 1'b1;
            r_state   <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign wb_cyc_o   = r_cyc;
  assign wb_stb_o   = r_stb;
  assign wb_we_o    = r_we;
  assign wb_adr_o   = r_adr;
  assign wb_dat_o   = r_dat;
  assign wb_sel_o   = {{(DATA_WIDTH/8-1){1'b0}}, 1'b1};
  assign err_o      = r_err;
  assign tx_ready_o = !r_tx_full;
  assign rx_valid_o = r_rx_full;
  assign rx_data_o  = r_rx_byte;

endmodule

// File: tb/tb_uart_wb_poll_master.sv
// Self-checking bench for uart_wb_poll_master. The bench plays the UART slave
// one transaction at a time: expected bus transactions and expected RX bytes are
// queued as stimulus is applied and popped when the DUT presents them.
module tb_uart_wb_poll_master;

  localparam int          POLL_GAP    = 4;
  localparam int          ACK_TIMEOUT = 255;
  localparam logic [31:0] ADR_DATA    = 32'h1000_0000;
  localparam logic [31:0] ADR_STAT    = 32'h1000_0004;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        wb_cyc_o, wb_stb_o, wb_ack_i, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i, err_o;
  logic [7:0]  tx_data_i, rx_data_o;

  uart_wb_poll_master #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .UART_BASE  (32'h1000_0000),
    .POLL_GAP   (POLL_GAP),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_ack_i   (wb_ack_i),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_sel_o   (wb_sel_o),
    .wb_we_o    (wb_we_o),
    .tx_valid_i (tx_valid_i),
    .tx_data_i  (tx_data_i),
    .tx_ready_o (tx_ready_o),
    .rx_valid_o (rx_valid_o),
    .rx_data_o  (rx_data_o),
    .rx_ready_i (rx_ready_i),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
  } txn_t;

  txn_t       exp_q[$];
  logic [7:0] rx_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int last_idle = 0;
  int err_cnt = 0;

  always @(negedge clk_i) if (err_o) err_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_txn(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    txn_t t;
    t.adr = adr;
    t.we  = we;
    t.dat = dat;
    exp_q.push_back(t);
  endtask

  // Called at a negedge. Waits for a request, checks it against the head of the
  // scoreboard, acks for one cycle with rdata, and checks the bus dropped.
  task automatic serve(input string tag, input logic [31:0] rdata, input int max_wait);
    int   n;
    txn_t e;
    n = 0;
    while (!(wb_cyc_o && wb_stb_o) && n < max_wait) begin
      @(negedge clk_i);
      n++;
    end
    last_idle = n;
    chk({tag, "_req_seen"}, {31'd0, wb_stb_o}, 32'd1);
    if (!wb_stb_o) return;
    chk({tag, "_sb_nonempty"}, {31'd0, exp_q.size() != 0}, 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk({tag, "_adr"}, wb_adr_o, e.adr);
    chk({tag, "_we"},  {31'd0, wb_we_o}, {31'd0, e.we});
    chk({tag, "_sel"}, {28'd0, wb_sel_o}, 32'h1);
    if (e.we) chk({tag, "_dat"}, wb_dat_o, e.dat);
    wb_dat_i = rdata;
    wb_ack_i = 1'b1;
    @(negedge clk_i);
    wb_ack_i = 1'b0;
    wb_dat_i = 32'h0;
    chk({tag, "_cyc_drop"}, {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
  endtask

  task automatic tx_send(input logic [7:0] b);
    chk("tx_ready_before_send", {31'd0, tx_ready_o}, 32'd1);
    tx_valid_i = 1'b1;
    tx_data_i  = b;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    chk("tx_ready_after_send", {31'd0, tx_ready_o}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int hi;
    int e0;
    logic [7:0] rb;

    rst_ni = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    tx_valid_i = 1'b0; tx_data_i = 8'h0; rx_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);

    chk("rst_cyc_stb_we", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_err_rxv", {30'd0, err_o, rx_valid_o}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready_o}, 32'd1);
    chk("rst_rx_data", {24'd0, rx_data_o}, 32'd0);
    rst_ni = 1'b1;

    // idle polling: STATUS=0x20 with nothing to send is unproductive
    push_txn(ADR_STAT, 1'b0, 32'h0);
    serve("poll1", 32'h20, 20);
    chk("poll1_tx_ready", {31'd0, tx_ready_o}, 32'd1);
    push_txn(ADR_STAT, 1'b0, 32'h0);
    serve("poll2", 32'h20, 20);
    // gap counter reloads to POLL_GAP and the launch is decided when it reads 0
    chk("poll_gap_idle", last_idle, POLL_GAP + 1);
    chk("poll2_tx_ready", {31'd0, tx_ready_o}, 32'd1);

    // single TX byte
    tx_send(8'h41);
    push_txn(ADR_STAT, 1'b0, 32'h0);
    push_txn(ADR_DATA, 1'b1, 32'h0000_0041);
    serve("tx41_stat", 32'h20, 20);
    serve("tx41_write", 32'h0, 20);
    chk("tx41_idle_before_write", {31'd0, last_idle >= 1}, 32'd1);
    chk("tx41_tx_ready_after", {31'd0, tx_ready_o}, 32'd1);

    // RX has priority when both are possible; TX follows on the next poll
    tx_send(8'h5A);
    push_txn(ADR_STAT, 1'b0, 32'h0);
    push_txn(ADR_DATA, 1'b0, 32'h0);
    push_txn(ADR_STAT, 1'b0, 32'h0);
    push_txn(ADR_DATA, 1'b1, 32'h0000_005A);
    serve("prio_stat", 32'h21, 20);
    serve("prio_rxread", 32'hFFFF_FFC3, 20);
    rx_q.push_back(8'hC3);
    chk("prio_rx_valid", {31'd0, rx_valid_o}, 32'd1);
    chk("prio_rx_data", {24'd0, rx_data_o}, 32'h0000_00C3);
    serve("prio_stat2", 32'h21, 20);
    serve("prio_txwrite", 32'h0, 20);

    // RX full, consumer stalled, nothing to send: bus must stay quiet
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (wb_cyc_o || wb_stb_o) n++;
    end
    chk("stall_no_bus", n, 0);
    chk("stall_rx_valid", {31'd0, rx_valid_o}, 32'd1);
    rx_ready_i = 1'b1;
    rb = rx_q.pop_front();
    chk("rx_pop_data", {24'd0, rx_data_o}, {24'd0, rb});
    @(negedge clk_i);
    rx_ready_i = 1'b0;
    chk("rx_pop_valid_clear", {31'd0, rx_valid_o}, 32'd0);
    push_txn(ADR_STAT, 1'b0, 32'h0);
    serve("resume_stat", 32'h00, POLL_GAP + 4);
    chk("resume_latency", {31'd0, last_idle <= POLL_GAP + 2}, 32'd1);

    // slave never acks the write
    chk("err_none_yet", err_cnt, 0);
    e0 = err_cnt;
    tx_send(8'h77);
    push_txn(ADR_STAT, 1'b0, 32'h0);
    serve("to_stat", 32'h20, 20);
    n = 0;
    while (!wb_stb_o && n < 20) begin @(negedge clk_i); n++; end
    chk("to_req_seen", {31'd0, wb_stb_o}, 32'd1);
    chk("to_adr", wb_adr_o, ADR_DATA);
    chk("to_we_dat", {wb_we_o, wb_dat_o[30:0]}, {1'b1, 31'h77});
    hi = 0;
    while (wb_stb_o && hi < ACK_TIMEOUT + 50) begin @(negedge clk_i); hi++; end
    chk("to_stb_cycles", hi, ACK_TIMEOUT);
    chk("to_cyc_low", {31'd0, wb_cyc_o}, 32'd0);
    repeat (3) @(negedge clk_i);
    chk("to_err_pulses", err_cnt - e0, 1);
    chk("to_tx_retained", {31'd0, tx_ready_o}, 32'd0);
    // stray ack while the bus is idle must be ignored
    wb_ack_i = 1'b1;
    @(negedge clk_i);
    wb_ack_i = 1'b0;
    push_txn(ADR_STAT, 1'b0, 32'h0);
    push_txn(ADR_DATA, 1'b1, 32'h0000_0077);
    serve("retry_stat", 32'h20, 20);
    serve("retry_write", 32'h0, 20);
    chk("retry_tx_ready", {31'd0, tx_ready_o}, 32'd1);
    chk("retry_err_pulses", err_cnt - e0, 1);

    // reset in the middle of a write
    tx_send(8'h99);
    push_txn(ADR_STAT, 1'b0, 32'h0);
    serve("rst_stat", 32'h20, 20);
    n = 0;
    while (!wb_stb_o && n < 20) begin @(negedge clk_i); n++; end
    chk("rst_txw_active", {30'd0, wb_stb_o, wb_we_o}, 32'd3);
    #2 rst_ni = 1'b0;
    #1 chk("rst_async_drop", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_release_tx_ready", {31'd0, tx_ready_o}, 32'd1);
    chk("sb_drained", exp_q.size() + rx_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
